gate_vector_seq: RTL and testbench

Self-checking stimulus sequencer that sits directly upstream of the `andgate` block and consumes its outputs. On `start` it drives `x`/`y` through the four input vectors 00, 01, 10, 11, holding each for `DWELL` cycles. At the end of each dwell it compares the five gate outputs against the expected truth table. It reports a per-vector fail mask, an error count and a pass flag, so the gate can be exercised in hardware or in a bench without a behavioural monitor.

---
 rtl/gate_vector_seq_pkg.sv | 35 +++
 rtl/gate_vector_seq_ref_model.sv | 18 +
 rtl/gate_vector_seq.sv | 108 ++++++++++
 tb/tb_gate_vector_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_vector_seq_pkg.sv
// Shared types and helpers for the gate_vector_seq stimulus sequencer.
// Holds the sequencer state encoding, vector count, the bit positions of the
// five gate outputs and the golden truth table for the andgate block.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int NUM_VEC = 4;

    // Bit positions inside the packed {z,f,h,k,b} gate-output vector
    localparam int BIT_Z = 4;
    localparam int BIT_F = 3;
    localparam int BIT_H = 2;
    localparam int BIT_K = 1;
    localparam int BIT_B = 0;

    // Golden outputs of the andgate block for one input pair
    function automatic logic [4:0] gate_expected(input logic x, input logic y);
        logic       a;
        logic [4:0] e;
        a        = x & y;
        e        = '0;
        e[BIT_Z] = a;
        e[BIT_F] = ~a;
        e[BIT_H] = ~a;
        e[BIT_K] = a;
        e[BIT_B] = a;
        return e;
    endfunction

endpackage

// File: rtl/gate_vector_seq_ref_model.sv
// Combinational reference check for one applied vector.
// Compares the observed five gate outputs with the golden truth table and
// flags any difference as a single mismatch bit.
module gate_ref_model
    import gate_seq_pkg::*;
(
    input  logic       x,
    input  logic       y,
    input  logic [4:0] observed,
    output logic       mismatch
);

    logic [4:0] expected;

    assign expected = gate_expected(x, y);
    assign mismatch = (observed != expected);

endmodule

// File: rtl/gate_vector_seq.sv
// Stimulus sequencer for the andgate block.
// Walks x/y through 00, 01, 10, 11 holding each for DWELL cycles, checks the
// five gate outputs in the last cycle of every dwell, and reports a per-vector
// fail mask, a failing-vector count and an overall pass flag.
module gate_vector_seq
    import gate_seq_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       x,
    output logic       y,
    input  logic       z_and,
    input  logic       k_and,
    input  logic       b_and,
    input  logic       f_nand,
    input  logic       h_nand,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int VEC_W = $clog2(NUM_VEC);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

    seq_state_t       state;
    logic [VEC_W-1:0] vec;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       observed;
    logic             mismatch;

    // Gate outputs packed in {z,f,h,k,b} order to line up with gate_expected
    assign observed = {z_and, f_nand, h_nand, k_and, b_and};

    gate_ref_model u_ref (
        .x        (x),
        .y        (y),
        .observed (observed),
        .mismatch (mismatch)
    );

    // Sequencer FSM: vector/dwell counters, registered gate drive and results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            cnt      <= '0;
            x        <= 1'b0;
            y        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= DRIVE;
                        vec      <= '0;
                        cnt      <= '0;
                        x        <= 1'b0;
                        y        <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (mismatch) begin
                            fail_vec[vec] <= 1'b1;
                            err_cnt       <= err_cnt + 3'd1;
                        end
                        if (vec == VEC_LAST) begin
                            state <= DONE;
                            vec   <= '0;
                            x     <= 1'b0;
                            y     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch && (err_cnt == 3'd0);
                        end else begin
                            vec      <= vec + VEC_W'(1);
                            {x, y}   <= vec + VEC_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_seq.sv
// Self-checking bench for gate_vector_seq with a behavioural andgate that can
// be switched into faulty modes. Expected per-cycle outputs are queued when a
// run is started and compared as the sequencer produces them.
module tb_gate_vector_seq;

    typedef struct packed {
        logic       x;
        logic       y;
        logic       busy;
        logic       done;
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } obs_t;

    logic clk;
    logic rst_n;
    logic start_a;
    logic start_b;
    int   fault_mode;

    logic       x_a, y_a, busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [3:0] fv_a;
    logic       z_a, k_a, b_a, f_a, h_a, and_a;

    logic       x_b, y_b, busy_b, done_b, pass_b;
    logic [2:0] err_b;
    logic [3:0] fv_b;
    logic       z_b, k_b, b_b, f_b, h_b, and_b;

    obs_t obs_a;
    obs_t obs_b;
    obs_t sb[$];

    int n_checks;
    int n_fail;

    // Behavioural andgate for each sequencer, with selectable faults
    assign and_a = x_a & y_a;
    assign z_a   = and_a;
    assign k_a   = and_a;
    assign b_a   = (fault_mode == 2 && x_a && y_a) ? ~and_a : and_a;
    assign f_a   = (fault_mode == 1) ? 1'b0 : ~and_a;
    assign h_a   = ~and_a;

    assign and_b = x_b & y_b;
    assign z_b   = and_b;
    assign k_b   = and_b;
    assign b_b   = (fault_mode == 2 && x_b && y_b) ? ~and_b : and_b;
    assign f_b   = (fault_mode == 1) ? 1'b0 : ~and_b;
    assign h_b   = ~and_b;

    assign obs_a = {x_a, y_a, busy_a, done_a, pass_a, err_a, fv_a};
    assign obs_b = {x_b, y_b, busy_b, done_b, pass_b, err_b, fv_b};

    gate_vector_seq #(.DWELL(10)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .x        (x_a),
        .y        (y_a),
        .z_and    (z_a),
        .k_and    (k_a),
        .b_and    (b_a),
        .f_nand   (f_a),
        .h_nand   (h_a),
        .busy     (busy_a),
        .done     (done_a),
        .pass     (pass_a),
        .err_cnt  (err_a),
        .fail_vec (fv_a)
    );

    gate_vector_seq #(.DWELL(1)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .x        (x_b),
        .y        (y_b),
        .z_and    (z_b),
        .k_and    (k_b),
        .b_and    (b_b),
        .f_nand   (f_nand_dummy_guard(f_b)),
        .h_nand   (h_b),
        .busy     (busy_b),
        .done     (done_b),
        .pass     (pass_b),
        .err_cnt  (err_b),
        .fail_vec (fv_b)
    );

    function automatic logic f_nand_dummy_guard(input logic v);
        return v;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Failing-vector mask the sequencer must report for each gate fault mode
    function automatic logic [3:0] fail_mask(input int mode);
        case (mode)
            1:       return 4'b0111;
            2:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Queue the expected outputs for every cycle of one run plus its done cycle
    task automatic push_run(input int dwell, input int mode);
        obs_t       e;
        logic [3:0] mask;
        logic [3:0] fv;
        logic [2:0] errs;
        logic [1:0] v;
        mask = fail_mask(mode);
        fv   = 4'b0000;
        errs = 3'd0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            for (int c = 0; c < dwell; c++) begin
                e.x    = v[1];
                e.y    = v[0];
                e.busy = 1'b1;
                e.done = 1'b0;
                e.pass = 1'b0;
                e.err  = errs;
                e.fv   = fv;
                sb.push_back(e);
            end
            if (mask[i]) begin
                fv[i] = 1'b1;
                errs  = errs + 3'd1;
            end
        end
        e.x    = 1'b0;
        e.y    = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b1;
        e.pass = (errs == 3'd0);
        e.err  = errs;
        e.fv   = fv;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_a !== 12'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got %b expected %b", obs_a, 12'b0);
        end
        n_checks++;
        if (obs_b !== 12'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_b: got %b expected %b", obs_b, 12'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs_a !== 12'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_a: got %b expected %b", obs_a, 12'b0);
        end
    endtask

    task automatic test_fault_run(input string name, input int mode);
        obs_t exp;
        int   k;
        fault_mode = mode;
        start_a    = 1'b1;
        push_run(10, mode);
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, k, obs_a, exp);
            end
            k++;
            @(negedge clk);
        end
        exp.x    = 1'b0;
        exp.y    = 1'b0;
        exp.busy = 1'b0;
        exp.done = 1'b1;
        exp.pass = (fail_mask(mode) == 4'b0000);
        exp.fv   = fail_mask(mode);
        exp.err  = 3'($countones(fail_mask(mode)));
        n_checks++;
        if (obs_a !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s hold: got %b expected %b", name, obs_a, exp);
        end
    endtask

    task automatic test_dwell_one();
        obs_t exp;
        int   k;
        fault_mode = 0;
        start_b    = 1'b1;
        push_run(1, 0);
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++;
            if (obs_b !== exp) begin
                n_fail++;
                $display("[TB] FAIL dwell_one cycle %0d: got %b expected %b", k, obs_b, exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t exp;
        int   k;
        fault_mode = 0;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if ({x_a, y_a, busy_a} !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL midrun_vec1: got %b expected %b", {x_a, y_a, busy_a}, 3'b011);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_a !== 12'b0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset: got %b expected %b", obs_a, 12'b0);
        end
        rst_n   = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        push_run(10, 0);
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("[TB] FAIL after_reset cycle %0d: got %b expected %b", k, obs_a, exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp;
        int   k;
        fault_mode = 1;
        start_a    = 1'b1;
        push_run(10, 1);
        push_run(10, 1);
        @(negedge clk);
        k = 0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", k, obs_a, exp);
            end
            if (sb.size() == 0) start_a = 1'b0;
            k++;
            @(negedge clk);
        end
        n_checks++;
        if ({busy_a, done_a} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_stop: got %b expected %b", {busy_a, done_a}, 2'b01);
        end
        fault_mode = 0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        fault_mode = 0;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        $display("[TB] gate_vector_seq bench starting");
        test_reset();
        test_fault_run("clean_run", 0);
        test_fault_run("fnand_stuck0", 1);
        test_fault_run("band_inv_11", 2);
        test_dwell_one();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
